// File: rtl/exe8_pkg.sv
// Shared constants and popcount-width helper for the exe8 balanced-word counter.
package exe8_pkg;

    localparam int EXE8_WIDTH = 4;
    localparam int EXE8_CNT_W = 8;

    // Bits needed to hold a count of 0..width set bits.
    function automatic int pop_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/exe8_popcount.sv
// Purely combinational set-bit counter used by exe8 to detect balanced words.
module popcount
    import exe8_pkg::*;
#(
    parameter int WIDTH = EXE8_WIDTH,
    localparam int PW   = pop_w(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [PW-1:0]    count_o
);

    // Sum the individual bits of the input word.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + PW'(data_i[i]);
        end
    end

endmodule

// File: rtl/exe8.sv
// Balanced-input event counter: counts sampled words with equal ones and zeros.
// Optional saturation at the counter maximum when EXE8_SATURATE_EN is defined.
module exe8
    import exe8_pkg::*;
#(
    parameter int WIDTH = EXE8_WIDTH,
    parameter int CNT_W = EXE8_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [CNT_W-1:0] equal_cnt
);

    localparam int             PW      = pop_w(WIDTH);
    localparam logic [PW-1:0]  HALF    = PW'(WIDTH / 2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PW-1:0]    ones_s;
    logic             balanced_s;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    popcount #(.WIDTH(WIDTH)) u_popcount (
        .data_i  (in),
        .count_o (ones_s)
    );

    assign balanced_s = (ones_s == HALF);

    // Next-count: bump on a balanced word, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (balanced_s) begin
`ifdef EXE8_SATURATE_EN
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
`else
            cnt_d = cnt_q + CNT_W'(1);
`endif
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign equal_cnt = cnt_q;

endmodule

// File: tb/tb_exe8.sv
// Self-checking bench for exe8: high-level reference model plus directed literal checks.
module tb_exe8;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_s;
    logic [7:0] equal_cnt;

    int checks;
    int errors;
    int m_cnt;

    exe8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_s),
        .equal_cnt (equal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tally of words with exactly two ones, as plain integer arithmetic.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
        end else if ($countones(in_s) == 2) begin
`ifdef EXE8_SATURATE_EN
            m_cnt <= (m_cnt >= 255) ? 255 : m_cnt + 1;
`else
            m_cnt <= (m_cnt + 1) % 256;
`endif
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checks = checks + 1;
        if (equal_cnt !== m_cnt[7:0]) begin
            errors = errors + 1;
            $display("FAIL model t=%0t got %0d expected %0d", $time, equal_cnt, m_cnt);
        end
    end

    task automatic check_lit(input string name, input int exp);
        checks = checks + 1;
        if (equal_cnt !== exp[7:0]) begin
            errors = errors + 1;
            $display("FAIL %s got %0d expected %0d", name, equal_cnt, exp);
        end
    endtask

    // Present a word, let one rising edge sample it, then settle.
    task automatic drive(input logic [3:0] v);
        in_s = v;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] bal_seq [4];
        logic [3:0] mix_seq [5];
        checks = 0;
        errors = 0;
        bal_seq = '{4'b1100, 4'b1010, 4'b0011, 4'b0101};
        mix_seq = '{4'b0000, 4'b0110, 4'b1111, 4'b0110, 4'b0001};

        // Reset held across edges with a balanced word present.
        rst_n = 1'b0;
        in_s  = 4'b1100;
        repeat (3) @(posedge clk);
        #2;
        check_lit("reset_hold", 0);

        in_s  = 4'b0000;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            drive(bal_seq[i]);
            check_lit("balanced_seq", i + 1);
        end

        drive(4'b0000);
        drive(4'b1111);
        drive(4'b0001);
        drive(4'b1110);
        drive(4'b0111);
        check_lit("unbalanced_hold", 4);

        for (int i = 0; i < 5; i++) drive(mix_seq[i]);
        check_lit("interleave_0110", 6);

        // Asynchronous clear between edges.
        #1 rst_n = 1'b0;
        #1 check_lit("async_reset", 0);
        in_s  = 4'b0000;
        rst_n = 1'b1;

        for (int v = 0; v < 16; v++) drive(4'(v));
        check_lit("exhaustive16", 6);

        // Deassert with a balanced word present: first edge counts it.
        #1 rst_n = 1'b0;
        in_s = 4'b1001;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #2;
        check_lit("deassert_counts", 1);

        repeat (254) drive(4'b1001);
        check_lit("reach_255", 255);
        drive(4'b1001);
`ifdef EXE8_SATURATE_EN
        check_lit("saturate_255", 255);
        drive(4'b1001);
        check_lit("saturate_hold", 255);
`else
        check_lit("wrap_0", 0);
        drive(4'b1001);
        check_lit("wrap_1", 1);
`endif

        drive(4'b0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
